alu_arbiter: RTL and testbench

//  Shares the single 8-bit add/sub ALU between two requesters (e.g. datapath issue

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter_rr_arb2.sv | 24 ++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states
// and the default datapath width.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Requester index -> one-hot bit position in the 2-bit handshake vectors.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// ReqValid/RspValid bit i belongs to requester i, and ready is only meaningful while valid.
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);

  logic [1:0]       ReqValid;
  logic [1:0]       ReqReady;
  logic [WIDTH-1:0] Req0A;
  logic [WIDTH-1:0] Req0B;
  logic             Req0Op;
  logic [WIDTH-1:0] Req1A;
  logic [WIDTH-1:0] Req1B;
  logic             Req1Op;

  logic [1:0]       RspValid;
  logic [1:0]       RspReady;
  logic [WIDTH-1:0] RspData;
  logic             RspZero;
  logic             RspLT;

  modport slave (
    input  ReqValid, Req0A, Req0B, Req0Op, Req1A, Req1B, Req1Op, RspReady,
    output ReqReady, RspValid, RspData, RspZero, RspLT
  );

  modport master (
    output ReqValid, Req0A, Req0B, Req0Op, Req1A, Req1B, Req1Op, RspReady,
    input  ReqReady, RspValid, RspData, RspZero, RspLT
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: the favoured requester wins a tie, otherwise
// whichever single requester is valid wins.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  logic w_other;

  assign w_other = ~i_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (i_valid[i_ptr]) begin
      o_grant = onehot2(i_ptr);
    end else if (i_valid[w_other]) begin
      o_grant = onehot2(w_other);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub ALU between two requesters: round-robin accept,
// one cycle of execution from registered operands, then a held response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter bit INIT_PTR = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluOp,
  input  logic [WIDTH-1:0] AluOut,
  input  logic             AluZero,
  input  logic             AluLT,
  output logic             Busy,
  output state_t           DbgState
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_lt;

  logic [1:0]       w_grant;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_valid;
  logic             w_accept;
  logic             w_capture;
  logic             w_grant_idx;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_op;

  rr_arb2 u_rr_arb2 (
    .i_valid (bus.ReqValid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_grant_idx = w_grant[1];
  assign w_sel_a     = w_grant_idx ? bus.Req1A  : bus.Req0A;
  assign w_sel_b     = w_grant_idx ? bus.Req1B  : bus.Req0B;
  assign w_sel_op    = w_grant_idx ? bus.Req1Op : bus.Req0Op;

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_req_ready = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_rsp_valid = onehot2(r_owner);
        // Only the owner's ready can release the held result.
        if (bus.RspReady[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr   <= INIT_PTR;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= ALU_OP_ADD;
    end else begin
      if (w_accept) begin
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_op    <= w_sel_op;
        r_owner <= w_grant_idx;
      end
      // The requester that just got served drops to second priority.
      if (w_capture) begin
        r_ptr <= ~r_owner;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_lt   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_data <= AluOut;
      r_rsp_zero <= AluZero;
      r_rsp_lt   <= AluLT;
    end
  end

  // ALU inputs come only from the operand registers so they never follow the request ports.
  assign AluA         = r_a;
  assign AluB         = r_b;
  assign AluOp        = r_op;

  assign bus.ReqReady = w_req_ready;
  assign bus.RspValid = w_rsp_valid;
  assign bus.RspData  = r_rsp_data;
  assign bus.RspZero  = r_rsp_zero;
  assign bus.RspLT    = r_rsp_lt;
  assign Busy         = (r_state != ST_IDLE);
  assign DbgState     = r_state;

  a_rsp_onehot : assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0(bus.RspValid));

  a_ready_idle : assert property (@(posedge Clk) disable iff (!Reset_n)
    (bus.ReqReady != 2'b00) |-> (r_state == ST_IDLE));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural add/sub ALU beside it and a
// transaction-level reference model of arbitration order, timing and results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [W-1:0] AluA, AluB, AluOut;
  logic         AluOp, AluZero, AluLT, Busy;
  state_t       DbgState;

  always #5 Clk = ~Clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W), .INIT_PTR(1'b0)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .bus      (bus),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluOp    (AluOp),
    .AluOut   (AluOut),
    .AluZero  (AluZero),
    .AluLT    (AluLT),
    .Busy     (Busy),
    .DbgState (DbgState)
  );

  // The ALU that sits next to the arbiter.
  assign AluOut  = (AluOp == ALU_OP_SUB) ? AluA - AluB : AluA + AluB;
  assign AluZero = (AluOut == '0);
  assign AluLT   = (AluA < AluB);

  int total = 0;
  int bad   = 0;

  // Reference model state: one op in flight, its age in cycles since accept.
  bit           m_inflight;
  int           m_age;
  bit           m_owner;
  bit           m_ptr;
  logic [W-1:0] m_a, m_b;
  logic         m_op;
  bit           auto_refill;
  logic [W+1:0] exp_q[$];      // {lt, zero, data}
  int           grant_log[$];
  logic [W+2:0] rsp_log[$];    // {owner, lt, zero, data}

  function automatic logic [W+1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
    int r;
    r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    r = (r + (2 ** W)) % (2 ** W);
    return {(a < b), (r == 0), r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_byte();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 8'h01;
      2:       return 8'hFF;
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic new_op(input int idx);
    if (idx == 0) begin
      bus.Req0A = rand_byte(); bus.Req0B = rand_byte(); bus.Req0Op = 1'($urandom_range(0, 1));
    end else begin
      bus.Req1A = rand_byte(); bus.Req1B = rand_byte(); bus.Req1Op = 1'($urandom_range(0, 1));
    end
    bus.ReqValid[idx] = 1'b1;
  endtask

  task automatic model_reset();
    m_inflight = 0; m_age = 0; m_ptr = 1'b0; m_owner = 1'b0;
    exp_q.delete(); grant_log.delete(); rsp_log.delete();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    bus.ReqValid = 2'b00;
    bus.RspReady = 2'b00;
    auto_refill = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  // One clock of scoreboarding: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [1:0]   exp_rdy, exp_rspv;
    logic [W+1:0] e;
    int           w;
    @(negedge Clk);
    exp_rdy = 2'b00;
    w = -1;
    if (!m_inflight) begin
      if (bus.ReqValid[m_ptr]) w = int'(m_ptr);
      else if (bus.ReqValid[!m_ptr]) w = int'(!m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    total++;
    if (bus.ReqReady !== exp_rdy) begin
      bad++; $display("FAIL req_ready: got %b want %b at %0t", bus.ReqReady, exp_rdy, $time);
    end
    exp_rspv = (m_inflight && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    total++;
    if (bus.RspValid !== exp_rspv) begin
      bad++; $display("FAIL rsp_valid: got %b want %b at %0t", bus.RspValid, exp_rspv, $time);
    end
    total++;
    if (Busy !== m_inflight) begin
      bad++; $display("FAIL busy: got %b want %b at %0t", Busy, m_inflight, $time);
    end
    if (exp_rspv != 2'b00 && exp_q.size() > 0) begin
      e = exp_q[0];
      total++;
      if ({bus.RspLT, bus.RspZero, bus.RspData} !== e) begin
        bad++; $display("FAIL rsp_data: got lt=%b z=%b d=%h want lt=%b z=%b d=%h at %0t",
                        bus.RspLT, bus.RspZero, bus.RspData, e[W+1], e[W], e[W-1:0], $time);
      end
    end
    if (m_inflight && m_age == 1) begin
      total++;
      if ({AluOp, AluA, AluB} !== {m_op, m_a, m_b}) begin
        bad++; $display("FAIL alu_in: got op=%b a=%h b=%h want op=%b a=%h b=%h",
                        AluOp, AluA, AluB, m_op, m_a, m_b);
      end
    end
    if (w >= 0) begin
      if (w == 0) {m_a, m_b, m_op} = {bus.Req0A, bus.Req0B, bus.Req0Op};
      else        {m_a, m_b, m_op} = {bus.Req1A, bus.Req1B, bus.Req1Op};
      exp_q.push_back(ref_alu(m_a, m_b, m_op));
      grant_log.push_back(w);
      m_inflight = 1; m_age = 1; m_owner = (w == 1); m_ptr = (w == 0);
    end else if (m_inflight) begin
      if (exp_rspv != 2'b00 && bus.RspReady[m_owner]) begin
        rsp_log.push_back({m_owner, bus.RspLT, bus.RspZero, bus.RspData});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_inflight = 0;
      end else begin
        m_age++;
      end
    end
    @(posedge Clk);
    #1;
    if (w >= 0) begin
      if (auto_refill) new_op(w);
      else bus.ReqValid[w] = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.ReqValid = 2'b00; bus.RspReady = 2'b00;
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({bus.ReqReady, bus.RspValid, bus.RspData, bus.RspZero, bus.RspLT, Busy} !== '0) begin
      bad++; $display("FAIL reset_outs: got rdy=%b v=%b d=%h z=%b lt=%b busy=%b want all 0",
                      bus.ReqReady, bus.RspValid, bus.RspData, bus.RspZero, bus.RspLT, Busy);
    end
    total++;
    if ({AluA, AluB, AluOp} !== '0 || DbgState !== ST_IDLE) begin
      bad++; $display("FAIL reset_alu: got a=%h b=%h op=%b st=%0d want 0 and idle",
                      AluA, AluB, AluOp, DbgState);
    end
    Reset_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_single_op();
    bus.Req0A = 8'h05; bus.Req0B = 8'h03; bus.Req0Op = ALU_OP_ADD;
    bus.ReqValid = 2'b01; bus.RspReady = 2'b01;
    for (int i = 0; i < 10 && rsp_log.size() < 1; i++) tick();
    total++;
    if (rsp_log.size() != 1) begin
      bad++; $display("FAIL single_timeout: got %0d responses want 1", rsp_log.size());
    end else if (rsp_log[0] !== {1'b0, 1'b0, 1'b0, 8'h08}) begin
      bad++; $display("FAIL single_result: got %h want %h", rsp_log[0], {3'b000, 8'h08});
    end
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    bus.Req0A = 8'h10; bus.Req0B = 8'h10; bus.Req0Op = ALU_OP_SUB;
    bus.Req1A = 8'h02; bus.Req1B = 8'h07; bus.Req1Op = ALU_OP_SUB;
    bus.ReqValid = 2'b11; bus.RspReady = 2'b11;
    for (int i = 0; i < 20 && rsp_log.size() < 2; i++) tick();
    total++;
    if (rsp_log.size() != 2) begin
      bad++; $display("FAIL tie_timeout: got %0d responses want 2", rsp_log.size());
    end else begin
      if (rsp_log[0] !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
        bad++; $display("FAIL tie_first: got %h want %h", rsp_log[0], {3'b001, 8'h00});
      end
      total++;
      if (rsp_log[1] !== {1'b1, 1'b1, 1'b0, 8'hFB}) begin
        bad++; $display("FAIL tie_second: got %h want %h", rsp_log[1], {3'b110, 8'hFB});
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    auto_refill = 1;
    new_op(0); new_op(1);
    bus.RspReady = 2'b11;
    for (int i = 0; i < 60 && grant_log.size() < 8; i++) tick();
    total++;
    if (grant_log.size() < 8) begin
      bad++; $display("FAIL fair_timeout: got %0d grants want 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (grant_log[i] !== (i % 2)) begin
          bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, grant_log[i], i % 2);
        end
      end
    end
    auto_refill = 0;
    bus.ReqValid = 2'b00;
    for (int i = 0; i < 10 && m_inflight; i++) tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    new_op(0); new_op(1);
    bus.RspReady = 2'b10;
    for (int i = 0; i < 6 && !(m_inflight && m_age >= 2); i++) tick();
    repeat (5) tick();
    total++;
    if (DbgState !== ST_HOLD || rsp_log.size() != 0) begin
      bad++; $display("FAIL bp_hold: got state=%0d rsps=%0d want state=%0d rsps=0",
                      DbgState, rsp_log.size(), ST_HOLD);
    end
    bus.RspReady = 2'b01;
    for (int i = 0; i < 10 && rsp_log.size() < 1; i++) tick();
    bus.RspReady = 2'b11;
    for (int i = 0; i < 10 && rsp_log.size() < 2; i++) tick();
    total++;
    if (rsp_log.size() != 2 || rsp_log[1][W+2] !== 1'b1) begin
      bad++; $display("FAIL bp_second: got %0d responses want 2 with req1 last", rsp_log.size());
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    new_op(0);
    bus.RspReady = 2'b11;
    for (int i = 0; i < 5 && grant_log.size() < 1; i++) tick();
    total++;
    if (DbgState !== ST_EXEC) begin
      bad++; $display("FAIL mid_exec: got state=%0d want %0d", DbgState, ST_EXEC);
    end
    Reset_n = 1'b0;
    #2;
    total++;
    if ({bus.RspValid, Busy, bus.RspData} !== '0 || DbgState !== ST_IDLE) begin
      bad++; $display("FAIL mid_reset: got v=%b busy=%b d=%h st=%0d want 0 and idle",
                      bus.RspValid, Busy, bus.RspData, DbgState);
    end
    model_reset();
    bus.ReqValid = 2'b00;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (10) tick();
    new_op(0); new_op(1);
    for (int i = 0; i < 20 && rsp_log.size() < 2; i++) tick();
    total++;
    if (grant_log.size() < 1 || grant_log[0] !== 0) begin
      bad++; $display("FAIL mid_ptr: got first grant %0d want 0",
                      (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!bus.ReqValid[r] && $urandom_range(0, 2) == 0) new_op(r);
        else if (bus.ReqValid[r] && $urandom_range(0, 15) == 0) bus.ReqValid[r] = 1'b0;
      end
      bus.RspReady = 2'($urandom_range(0, 3));
      tick();
    end
    bus.ReqValid = 2'b00;
    bus.RspReady = 2'b11;
    for (int i = 0; i < 10 && m_inflight; i++) tick();
    total++;
    if (m_inflight || exp_q.size() != 0) begin
      bad++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.ReqValid = 2'b00; bus.RspReady = 2'b00;
    bus.Req0A = '0; bus.Req0B = '0; bus.Req0Op = 1'b0;
    bus.Req1A = '0; bus.Req1B = '0; bus.Req1Op = 1'b0;
    auto_refill = 0;
    test_reset();
    test_single_op();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
